trigger_sequencer: RTL and testbench

//  Multi-stage serial trigger; parametrised successor to the single-stage rising/falling trigger.

---
 rtl/trigger_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_trigger_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: ordered multi-stage mask/value trigger with per-stage post-match delay.
// Optional build macro TRIG_EDGE_EN adds per-stage rise/fall edge qualifiers on the sampled word.
module trigger_sequencer #(
  parameter  int SAMPLE_WIDTH = 8,
  parameter  int NUM_STAGES   = 4,
  parameter  int DELAY_WIDTH  = 16,
  localparam int SELW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load_stage,
  input  logic [SELW-1:0]         stage_sel,
  input  logic [SAMPLE_WIDTH-1:0] cfg_mask,
  input  logic [SAMPLE_WIDTH-1:0] cfg_value,
  input  logic [DELAY_WIDTH-1:0]  cfg_delay,
  input  logic                    cfg_last,
  input  logic [SAMPLE_WIDTH-1:0] cfg_rise,
  input  logic [SAMPLE_WIDTH-1:0] cfg_fall,
  input  logic                    arm,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  output logic                    run,
  output logic                    armed,
  output logic [SELW-1:0]         stage_idx
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DELAY = 2'd2, FIRED = 2'd3} state_t;

  localparam logic [SELW-1:0]         LAST_IDX  = SELW'(NUM_STAGES - 1);
  localparam logic [SELW-1:0]         IDX_ZERO  = {SELW{1'b0}};
  localparam logic [DELAY_WIDTH-1:0]  CNT_ZERO  = {DELAY_WIDTH{1'b0}};
  localparam logic [SAMPLE_WIDTH-1:0] WORD_ZERO = {SAMPLE_WIDTH{1'b0}};

  function automatic logic level_match(input logic [SAMPLE_WIDTH-1:0] d,
                                       input logic [SAMPLE_WIDTH-1:0] v,
                                       input logic [SAMPLE_WIDTH-1:0] m);
    return ((d ^ v) & m) == WORD_ZERO;
  endfunction

  state_t                  state_r, state_s;
  logic [DELAY_WIDTH-1:0]  cnt_r, cnt_s, cnt_inc_s;
  logic [SELW-1:0]         stage_idx_r, idx_s;
  logic                    run_r, armed_r;
  logic                    cfg_wr_s, match_s, advance_s;

  logic [SAMPLE_WIDTH-1:0] mask_r  [NUM_STAGES];
  logic [SAMPLE_WIDTH-1:0] value_r [NUM_STAGES];
  logic [DELAY_WIDTH-1:0]  delay_r [NUM_STAGES];
  logic [NUM_STAGES-1:0]   last_r;

  assign cfg_wr_s  = load_stage && (state_r == IDLE) && (32'(stage_sel) < NUM_STAGES);
  assign cnt_inc_s = cnt_r + DELAY_WIDTH'(1'b1);

  // Stage configuration storage; only writable while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        mask_r[i]  <= WORD_ZERO;
        value_r[i] <= WORD_ZERO;
        delay_r[i] <= CNT_ZERO;
      end
      last_r <= {NUM_STAGES{1'b0}};
    end else if (cfg_wr_s) begin
      mask_r[stage_sel]  <= cfg_mask;
      value_r[stage_sel] <= cfg_value;
      delay_r[stage_sel] <= cfg_delay;
      last_r[stage_sel]  <= cfg_last;
    end
  end

`ifdef TRIG_EDGE_EN
  logic [SAMPLE_WIDTH-1:0] rise_r [NUM_STAGES];
  logic [SAMPLE_WIDTH-1:0] fall_r [NUM_STAGES];
  logic [SAMPLE_WIDTH-1:0] prev_r;

  // Edge qualifiers per stage plus the previous valid sample (tracked even while idle).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        rise_r[i] <= WORD_ZERO;
        fall_r[i] <= WORD_ZERO;
      end
      prev_r <= WORD_ZERO;
    end else begin
      if (cfg_wr_s) begin
        rise_r[stage_sel] <= cfg_rise;
        fall_r[stage_sel] <= cfg_fall;
      end
      if (valid) begin
        prev_r <= dataIn;
      end
    end
  end

  // Current-stage compare: level plus required rising/falling bits.
  always_comb begin
    match_s = valid
           && level_match(dataIn, value_r[stage_idx_r], mask_r[stage_idx_r])
           && ((~prev_r & dataIn & rise_r[stage_idx_r]) == rise_r[stage_idx_r])
           && ((prev_r & ~dataIn & fall_r[stage_idx_r]) == fall_r[stage_idx_r]);
  end
`else
  logic unused_edge_s;
  assign unused_edge_s = ^{cfg_rise, cfg_fall};

  // Current-stage compare: level only.
  always_comb begin
    match_s = valid && level_match(dataIn, value_r[stage_idx_r], mask_r[stage_idx_r]);
  end
`endif

  // Next-state logic; arm low overrides everything, one stage advance per sample.
  always_comb begin
    state_s   = state_r;
    idx_s     = stage_idx_r;
    cnt_s     = cnt_r;
    advance_s = 1'b0;
    if (!arm) begin
      state_s = IDLE;
      idx_s   = IDX_ZERO;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = ARMED;
          idx_s   = IDX_ZERO;
          cnt_s   = CNT_ZERO;
        end
        ARMED: begin
          if (match_s) begin
            if (delay_r[stage_idx_r] == CNT_ZERO) begin
              advance_s = 1'b1;
            end else begin
              cnt_s   = CNT_ZERO;
              state_s = DELAY;
            end
          end else begin
            state_s = ARMED;
          end
        end
        DELAY: begin
          if (valid) begin
            if (cnt_inc_s == delay_r[stage_idx_r]) begin
              advance_s = 1'b1;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            state_s = DELAY;
          end
        end
        FIRED: begin
          state_s = FIRED;
        end
        default: begin
          state_s = IDLE;
          idx_s   = IDX_ZERO;
          cnt_s   = CNT_ZERO;
        end
      endcase
      if (advance_s) begin
        cnt_s = CNT_ZERO;
        if (last_r[stage_idx_r] || (stage_idx_r == LAST_IDX)) begin
          state_s = FIRED;
        end else begin
          idx_s   = stage_idx_r + SELW'(1'b1);
          state_s = ARMED;
        end
      end else begin
        cnt_s = cnt_s;
      end
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      stage_idx_r <= IDX_ZERO;
      run_r       <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      stage_idx_r <= idx_s;
      run_r       <= (state_s == FIRED);
      armed_r     <= (state_s == ARMED) || (state_s == DELAY);
    end
  end

  assign run       = run_r;
  assign armed     = armed_r;
  assign stage_idx = stage_idx_r;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench for trigger_sequencer: expected run edges are queued by the stimulus,
// a negedge monitor pops and compares them; status outputs are checked directly.
module tb_trigger_sequencer;
  localparam int SW = 8, NS = 4, DW = 16, SELW = 2;

  logic            clock = 1'b0;
  logic            reset_n, load_stage, cfg_last, arm, valid;
  logic [SELW-1:0] stage_sel;
  logic [SW-1:0]   cfg_mask, cfg_value, cfg_rise, cfg_fall, dataIn;
  logic [DW-1:0]   cfg_delay;
  logic            run, armed;
  logic [SELW-1:0] stage_idx;

  trigger_sequencer #(.SAMPLE_WIDTH(SW), .NUM_STAGES(NS), .DELAY_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n), .load_stage(load_stage), .stage_sel(stage_sel),
    .cfg_mask(cfg_mask), .cfg_value(cfg_value), .cfg_delay(cfg_delay), .cfg_last(cfg_last),
    .cfg_rise(cfg_rise), .cfg_fall(cfg_fall), .arm(arm), .valid(valid), .dataIn(dataIn),
    .run(run), .armed(armed), .stage_idx(stage_idx));

  always #5 clock = ~clock;

  typedef struct { int cyc; int idx; int tag; } exp_t;
  exp_t sb_q[$];
  int   total = 0, bad = 0, ncyc = 0;
  logic run_q = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of run must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      ncyc++;
      if (run && !run_q) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_fire: run rose at cycle %0d with no fire expected", ncyc);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("fire%0d_cycle", e.tag), ncyc, e.cyc);
          check($sformatf("fire%0d_stage_idx", e.tag), int'(stage_idx), e.idx);
        end
      end
      run_q = run;
    end
  end

  task automatic drive(input logic a, input logic v, input logic [SW-1:0] d);
    @(posedge clock); #1;
    arm = a; valid = v; dataIn = d; load_stage = 1'b0;
  endtask

  task automatic load(input logic [SELW-1:0] s, input logic [SW-1:0] m, input logic [SW-1:0] v,
                      input logic [DW-1:0] dly, input logic lst,
                      input logic [SW-1:0] r, input logic [SW-1:0] f);
    @(posedge clock); #1;
    load_stage = 1'b1; stage_sel = s; cfg_mask = m; cfg_value = v;
    cfg_delay = dly; cfg_last = lst; cfg_rise = r; cfg_fall = f; valid = 1'b0;
  endtask

  // The completing sample is taken at the next posedge; run shows at the negedge after that.
  task automatic expect_fire(input int tag, input int idx);
    exp_t e;
    e.cyc = ncyc + 2; e.idx = idx; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0; arm = 1'b0; valid = 1'b0; load_stage = 1'b0;
    #3 reset_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    reset_n = 1'b0; arm = 1'b0; valid = 1'b0; dataIn = 8'h00; load_stage = 1'b0;
    stage_sel = 2'd0; cfg_mask = 8'h00; cfg_value = 8'h00; cfg_delay = 16'd0;
    cfg_last = 1'b0; cfg_rise = 8'h00; cfg_fall = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("rst_run", int'(run), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_stage_idx", int'(stage_idx), 0);
    reset_n = 1'b1;

    // single stage, exact A5
    load(2'd0, 8'hFF, 8'hA5, 16'd0, 1'b1, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'hA5); expect_fire(1, 0);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    check("t1_run_held", int'(run), 1);
    check("t1_armed_after_fire", int'(armed), 0);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    check("t1_run_cleared", int'(run), 0);

    // three stages 01,02,03; out-of-order 03 ignored
    do_reset();
    load(2'd0, 8'hFF, 8'h01, 16'd0, 1'b0, 8'h00, 8'h00);
    load(2'd1, 8'hFF, 8'h02, 16'd0, 1'b0, 8'h00, 8'h00);
    load(2'd2, 8'hFF, 8'h03, 16'd0, 1'b1, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b1, 1'b1, 8'h03); check("t2_idx_after_01", int'(stage_idx), 1);
    drive(1'b1, 1'b1, 8'h02); check("t2_idx_after_03", int'(stage_idx), 1);
    drive(1'b1, 1'b1, 8'h03); check("t2_idx_after_02", int'(stage_idx), 2); expect_fire(2, 2);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // drop arm mid-sequence (with a coincident stage-1 match), then restart at stage 0
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b1, 1'b0, 8'h00);
    check("t4_idx_mid", int'(stage_idx), 1);
    check("t4_armed_mid", int'(armed), 1);
    drive(1'b0, 1'b1, 8'h02);
    drive(1'b1, 1'b0, 8'h00);
    check("t4_idx_cleared", int'(stage_idx), 0);
    check("t4_armed_cleared", int'(armed), 0);
    check("t4_run_cleared", int'(run), 0);
    drive(1'b1, 1'b1, 8'h02);
    drive(1'b1, 1'b1, 8'h01); check("t4_idx_restart", int'(stage_idx), 0);
    drive(1'b1, 1'b1, 8'h02);
    drive(1'b1, 1'b1, 8'h03); expect_fire(4, 2);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // config write while armed must be ignored
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    load(2'd0, 8'hFF, 8'h55, 16'd0, 1'b1, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 8'h55);
    drive(1'b1, 1'b1, 8'h01); check("t5_idx_after_55", int'(stage_idx), 0);
    drive(1'b1, 1'b1, 8'h02);
    drive(1'b1, 1'b1, 8'h03); expect_fire(5, 2);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // post-match delay of 3 valid samples with idle gaps
    do_reset();
    load(2'd0, 8'hFF, 8'h10, 16'd3, 1'b1, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h10);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    check("t3_armed_in_delay", int'(armed), 1);
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    check("t3_run_before_3rd", int'(run), 0);
    drive(1'b1, 1'b1, 8'h00); expect_fire(3, 0);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // mask 0 matches any valid sample
    do_reset();
    load(2'd0, 8'h00, 8'h00, 16'd0, 1'b1, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h77); expect_fire(6, 0);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

`ifdef TRIG_EDGE_EN
    // rising edge on bit 0 only
    do_reset();
    load(2'd0, 8'h00, 8'h00, 16'd0, 1'b1, 8'h01, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'h01); expect_fire(7, 0);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    check("edge_no_fire_on_level", int'(run), 0);
    drive(1'b0, 1'b0, 8'h00);
`endif

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      total++;
      bad++;
      $display("FAIL fire%0d_missing: run never rose, expected at cycle %0d", e.tag, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
